// File: rtl/fxu_issue_queue_pkg.sv
// Shared definitions for the FXU issue queue: opcodes, default widths, allocation helper.
package fxu_issue_queue_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MOV  = 4'd4;
  localparam logic [3:0] OP_MOVL = 4'd5;
  localparam logic [3:0] OP_MOVH = 4'd6;

  localparam int TAG_W_DEF   = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int ENTRIES_MAX = 8;

  // Isolates the lowest set bit; used to pick the lowest-numbered free slot.
  function automatic logic [ENTRIES_MAX-1:0] lowest_one(input logic [ENTRIES_MAX-1:0] v);
    return v & (~v + 1'b1);
  endfunction

endpackage

// File: rtl/fxu_issue_queue_if.sv
// Dispatch, CDB snoop and FXU issue signals of the issue queue.
interface fxu_issue_queue_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 16
);
  // Dispatch transfers on a cycle where disp_valid && disp_ready; disp_ready depends only on
  // registered queue state, and the dispatcher holds its payload until it transfers.
  logic              disp_valid;
  logic              disp_ready;
  logic [3:0]        disp_opcode;
  logic [TAG_W-1:0]  disp_index;
  logic              disp_a_rdy;
  logic [TAG_W-1:0]  disp_a_tag;
  logic [DATA_W-1:0] disp_va;
  logic              disp_b_rdy;
  logic [TAG_W-1:0]  disp_b_tag;
  logic [DATA_W-1:0] disp_vb;
  logic [7:0]        disp_i;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;

  logic              iss_valid;
  logic [3:0]        iss_opcode;
  logic [TAG_W-1:0]  iss_index;
  logic [DATA_W-1:0] iss_va;
  logic [DATA_W-1:0] iss_vb;
  logic [7:0]        iss_i;

  modport master (
    output disp_valid, disp_opcode, disp_index, disp_a_rdy, disp_a_tag, disp_va,
           disp_b_rdy, disp_b_tag, disp_vb, disp_i, cdb_valid, cdb_tag, cdb_value,
    input  disp_ready, iss_valid, iss_opcode, iss_index, iss_va, iss_vb, iss_i
  );

  modport slave (
    input  disp_valid, disp_opcode, disp_index, disp_a_rdy, disp_a_tag, disp_va,
           disp_b_rdy, disp_b_tag, disp_vb, disp_i, cdb_valid, cdb_tag, cdb_value,
    output disp_ready, iss_valid, iss_opcode, iss_index, iss_va, iss_vb, iss_i
  );
endinterface

// File: rtl/fxu_iq_pick.sv
// Oldest-ready picker: older[e][j] set means entry j is older than entry e.
module fxu_iq_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [N-1:0][N-1:0] older,
  output logic [N-1:0]        grant,
  output logic                any
);

  // An entry wins when no older entry is also requesting.
  always_comb begin
    for (int e = 0; e < N; e++) begin
      grant[e] = req[e] && !(|(older[e] & req));
    end
  end

  assign any = |req;

endmodule

// File: rtl/fxu_issue_queue.sv
// Reservation station in front of the FXU: buffers ops, snoops the CDB, issues oldest ready op.
module fxu_issue_queue
  import fxu_issue_queue_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  fxu_issue_queue_if.slave               bus,
  output logic [$clog2(ENTRIES+1)-1:0]   occupancy
);

  localparam int SEL_W = $clog2(ENTRIES);
  localparam int OCC_W = $clog2(ENTRIES+1);

  logic [ENTRIES-1:0]              valid, a_rdy, b_rdy;
  logic [3:0]                      opcode [ENTRIES];
  logic [TAG_W-1:0]                index  [ENTRIES];
  logic [TAG_W-1:0]                a_tag  [ENTRIES];
  logic [TAG_W-1:0]                b_tag  [ENTRIES];
  logic [DATA_W-1:0]               va     [ENTRIES];
  logic [DATA_W-1:0]               vb     [ENTRIES];
  logic [7:0]                      imm    [ENTRIES];
  logic [ENTRIES-1:0][ENTRIES-1:0] older;

  logic [ENTRIES-1:0]     req, grant, grant_eff, alloc;
  logic [ENTRIES_MAX-1:0] free_oh;
  logic                   req_any, issue_en, disp_fire;
  logic [SEL_W-1:0]       sel;
  logic                   disp_a_rdy_eff, disp_b_rdy_eff;
  logic [DATA_W-1:0]      disp_va_eff, disp_vb_eff;

  assign req = valid & a_rdy & b_rdy;

  fxu_iq_pick #(.N(ENTRIES)) u_pick (
    .req   (req),
    .older (older),
    .grant (grant),
    .any   (req_any)
  );

  assign issue_en  = req_any && !flush;
  assign grant_eff = issue_en ? grant : '0;

  always_comb begin
    sel = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (grant[e]) sel = SEL_W'(e);
    end
  end

  // Full is judged on start-of-cycle state, so a slot freed by this cycle's issue waits a cycle.
  assign bus.disp_ready = !(&valid);
  assign disp_fire      = bus.disp_valid && bus.disp_ready && !flush;

  always_comb begin
    free_oh = lowest_one(ENTRIES_MAX'(~valid));
    alloc   = disp_fire ? free_oh[ENTRIES-1:0] : '0;
  end

  // A result on the CDB in the dispatch cycle is captured directly into the new entry.
  assign disp_a_rdy_eff = bus.disp_a_rdy || (bus.cdb_valid && bus.cdb_tag == bus.disp_a_tag);
  assign disp_b_rdy_eff = bus.disp_b_rdy || (bus.cdb_valid && bus.cdb_tag == bus.disp_b_tag);
  assign disp_va_eff    = bus.disp_a_rdy ? bus.disp_va : bus.cdb_value;
  assign disp_vb_eff    = bus.disp_b_rdy ? bus.disp_vb : bus.cdb_value;

  always_comb begin
    bus.iss_valid  = issue_en;
    bus.iss_opcode = '0;
    bus.iss_index  = '0;
    bus.iss_va     = '0;
    bus.iss_vb     = '0;
    bus.iss_i      = '0;
    if (issue_en) begin
      bus.iss_opcode = opcode[sel];
      bus.iss_index  = index[sel];
      bus.iss_va     = va[sel];
      bus.iss_vb     = vb[sel];
      bus.iss_i      = imm[sel];
    end
  end

  always_comb begin
    occupancy = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      occupancy = occupancy + OCC_W'(valid[e]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      a_rdy <= '0;
      b_rdy <= '0;
      older <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        opcode[e] <= '0;
        index[e]  <= '0;
        a_tag[e]  <= '0;
        b_tag[e]  <= '0;
        va[e]     <= '0;
        vb[e]     <= '0;
        imm[e]    <= '0;
      end
    end else if (flush) begin
      valid <= '0;
      older <= '0;
    end else begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (alloc[e]) begin
          valid[e]  <= 1'b1;
          opcode[e] <= bus.disp_opcode;
          index[e]  <= bus.disp_index;
          a_rdy[e]  <= disp_a_rdy_eff;
          a_tag[e]  <= bus.disp_a_tag;
          va[e]     <= disp_va_eff;
          b_rdy[e]  <= disp_b_rdy_eff;
          b_tag[e]  <= bus.disp_b_tag;
          vb[e]     <= disp_vb_eff;
          imm[e]    <= bus.disp_i;
          older[e]  <= valid & ~grant_eff;
        end else begin
          if (grant_eff[e]) valid[e] <= 1'b0;
          older[e] <= older[e] & ~grant_eff;
          if (bus.cdb_valid && !a_rdy[e] && a_tag[e] == bus.cdb_tag) begin
            a_rdy[e] <= 1'b1;
            va[e]    <= bus.cdb_value;
          end
          if (bus.cdb_valid && !b_rdy[e] && b_tag[e] == bus.cdb_tag) begin
            b_rdy[e] <= 1'b1;
            vb[e]    <= bus.cdb_value;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fxu_issue_queue.sv
// Scoreboard bench for fxu_issue_queue: expected issue records are queued at dispatch time.
module tb_fxu_issue_queue;
  import fxu_issue_queue_pkg::*;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 16;
  localparam int REC_W  = 4 + TAG_W + 2*DATA_W + 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] occupancy;

  fxu_issue_queue_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  fxu_issue_queue #(.ENTRIES(4), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [REC_W-1:0] exp_q[$];

  function automatic logic [REC_W-1:0] rec(input logic [3:0] op, input logic [TAG_W-1:0] idx,
                                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                           input logic [7:0] i);
    return {op, idx, a, b, i};
  endfunction

  task automatic check(input string tag, input logic [REC_W-1:0] got, input logic [REC_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_valid = 1'b0; bus.disp_opcode = '0; bus.disp_index = '0;
    bus.disp_a_rdy = 1'b0; bus.disp_a_tag = '0; bus.disp_va = '0;
    bus.disp_b_rdy = 1'b0; bus.disp_b_tag = '0; bus.disp_vb = '0; bus.disp_i = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_value = '0;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [TAG_W-1:0] idx,
                          input logic ar, input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] a,
                          input logic br, input logic [TAG_W-1:0] bt, input logic [DATA_W-1:0] b,
                          input logic [7:0] i, input bit expect_issue,
                          input logic [DATA_W-1:0] exp_a, input logic [DATA_W-1:0] exp_b);
    bus.disp_valid = 1'b1; bus.disp_opcode = op; bus.disp_index = idx;
    bus.disp_a_rdy = ar; bus.disp_a_tag = at; bus.disp_va = a;
    bus.disp_b_rdy = br; bus.disp_b_tag = bt; bus.disp_vb = b; bus.disp_i = i;
    if (expect_issue) exp_q.push_back(rec(op, idx, exp_a, exp_b, i));
    step();
    bus.disp_valid = 1'b0;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] value);
    bus.cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_value = value;
    step();
    bus.cdb_valid = 1'b0;
  endtask

  // Every issued op must match the head of the expected queue; idle payload must be zero.
  always @(negedge clk) begin
    logic [REC_W-1:0] got, exp;
    got = {bus.iss_opcode, bus.iss_index, bus.iss_va, bus.iss_vb, bus.iss_i};
    if (rst_n && bus.iss_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", REC_W'(bus.iss_valid), '0);
      end else begin
        exp = exp_q.pop_front();
        check("issue_record", got, exp);
      end
    end else if (rst_n && !flush) begin
      check("idle_payload", got, '0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    // Reset values
    #3;
    check("rst_iss_valid", REC_W'(bus.iss_valid), '0);
    check("rst_disp_ready", REC_W'(bus.disp_ready), REC_W'(1));
    check("rst_occupancy", REC_W'(occupancy), '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(); step();
    check("idle_iss_valid", REC_W'(bus.iss_valid), '0);
    check("idle_disp_ready", REC_W'(bus.disp_ready), REC_W'(1));
    check("idle_occupancy", REC_W'(occupancy), '0);

    // Both operands ready: issue in the cycle after dispatch
    dispatch(OP_ADD, 4'd3, 1'b1, 4'd0, 16'h0005, 1'b1, 4'd0, 16'h0007, 8'h00, 1'b1, 16'h0005, 16'h0007);
    check("ready_iss_valid", REC_W'(bus.iss_valid), REC_W'(1));
    check("ready_iss_index", REC_W'(bus.iss_index), REC_W'(3));
    check("ready_occupancy", REC_W'(occupancy), REC_W'(1));
    step();
    check("ready_drained", REC_W'(bus.iss_valid), '0);
    check("ready_occ_zero", REC_W'(occupancy), '0);

    // Wakeup of operand A from the CDB
    dispatch(OP_SUB, 4'd2, 1'b0, 4'd9, 16'hDEAD, 1'b1, 4'd0, 16'h0001, 8'h11, 1'b1, 16'h0010, 16'h0001);
    check("wait_no_issue", REC_W'(bus.iss_valid), '0);
    check("wait_occupancy", REC_W'(occupancy), REC_W'(1));
    cdb(4'd8, 16'h1234);
    check("wrong_tag_no_issue", REC_W'(bus.iss_valid), '0);
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd9; bus.cdb_value = 16'h0010;
    #1;
    check("cdb_cycle_no_issue", REC_W'(bus.iss_valid), '0);
    step();
    bus.cdb_valid = 1'b0;
    check("woken_iss_valid", REC_W'(bus.iss_valid), REC_W'(1));
    step();
    check("woken_drained", REC_W'(bus.iss_valid), '0);

    // Same-cycle bypass on operand B
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd9; bus.cdb_value = 16'h0020;
    dispatch(OP_MOV, 4'd6, 1'b1, 4'd0, 16'h0003, 1'b0, 4'd9, 16'h0000, 8'h22, 1'b1, 16'h0003, 16'h0020);
    bus.cdb_valid = 1'b0;
    check("bypass_iss_valid", REC_W'(bus.iss_valid), REC_W'(1));
    step();
    check("bypass_drained", REC_W'(bus.iss_valid), '0);

    // Age order across a full queue, plus dispatch concurrent with issue
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] op;
      case (k)
        1: op = OP_ADD;
        2: op = OP_MOVL;
        3: op = 4'hF;
        default: op = OP_MOVH;
      endcase
      dispatch(op, TAG_W'(k), 1'b0, 4'd7, 16'h0000, 1'b1, 4'd0, DATA_W'(16'h0100 + k),
               8'(8'h40 + k), 1'b1, 16'h0077, DATA_W'(16'h0100 + k));
      check("fill_no_issue", REC_W'(bus.iss_valid), '0);
    end
    check("full_disp_ready", REC_W'(bus.disp_ready), '0);
    check("full_occupancy", REC_W'(occupancy), REC_W'(4));
    cdb(4'd7, 16'h0077);
    check("age_first_index", REC_W'(bus.iss_index), REC_W'(1));
    check("full_issue_ready", REC_W'(bus.disp_ready), '0);
    step();
    check("age_second_index", REC_W'(bus.iss_index), REC_W'(2));
    check("after_issue_ready", REC_W'(bus.disp_ready), REC_W'(1));
    check("after_issue_occ", REC_W'(occupancy), REC_W'(3));
    dispatch(OP_MOV, 4'd5, 1'b1, 4'd0, 16'h0055, 1'b1, 4'd0, 16'h0066, 8'h05, 1'b1, 16'h0055, 16'h0066);
    check("disp_issue_occ", REC_W'(occupancy), REC_W'(3));
    check("age_third_index", REC_W'(bus.iss_index), REC_W'(3));
    step();
    check("age_fourth_index", REC_W'(bus.iss_index), REC_W'(4));
    step();
    check("young_last_index", REC_W'(bus.iss_index), REC_W'(5));
    step();
    check("age_drained", REC_W'(bus.iss_valid), '0);
    check("age_occ_zero", REC_W'(occupancy), '0);

    // Flush with ready candidates and a dispatch in the flush cycle
    dispatch(OP_ADD, 4'd8, 1'b0, 4'd5, 16'h0, 1'b1, 4'd0, 16'h0001, 8'h08, 1'b0, 16'h0, 16'h0);
    dispatch(OP_SUB, 4'd9, 1'b0, 4'd5, 16'h0, 1'b1, 4'd0, 16'h0002, 8'h09, 1'b0, 16'h0, 16'h0);
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd5; bus.cdb_value = 16'h0099;
    dispatch(OP_ADD, 4'd10, 1'b0, 4'd5, 16'h0, 1'b1, 4'd0, 16'h0003, 8'h0A, 1'b0, 16'h0, 16'h0);
    bus.cdb_valid = 1'b0;
    flush = 1'b1;
    bus.disp_valid = 1'b1; bus.disp_opcode = OP_ADD; bus.disp_index = 4'd11;
    bus.disp_a_rdy = 1'b1; bus.disp_b_rdy = 1'b1; bus.disp_va = 16'h0001; bus.disp_vb = 16'h0001;
    #1;
    check("flush_iss_valid", REC_W'(bus.iss_valid), '0);
    step();
    flush = 1'b0;
    bus.disp_valid = 1'b0;
    check("flush_occupancy", REC_W'(occupancy), '0);
    check("flush_disp_ready", REC_W'(bus.disp_ready), REC_W'(1));
    cdb(4'd5, 16'h0099);
    repeat (3) begin
      check("flush_no_issue", REC_W'(bus.iss_valid), '0);
      step();
    end

    // Asynchronous reset while an op is being issued
    dispatch(OP_ADD, 4'd12, 1'b0, 4'd6, 16'h0, 1'b1, 4'd0, 16'h000C, 8'h0C, 1'b0, 16'h0, 16'h0);
    dispatch(OP_SUB, 4'd13, 1'b0, 4'd6, 16'h0, 1'b1, 4'd0, 16'h000D, 8'h0D, 1'b0, 16'h0, 16'h0);
    check("pre_reset_occ", REC_W'(occupancy), REC_W'(2));
    cdb(4'd6, 16'h0066);
    check("pre_reset_iss_valid", REC_W'(bus.iss_valid), REC_W'(1));
    #1 rst_n = 1'b0;
    #1;
    check("async_iss_valid", REC_W'(bus.iss_valid), '0);
    check("async_disp_ready", REC_W'(bus.disp_ready), REC_W'(1));
    check("async_occupancy", REC_W'(occupancy), '0);
    check("async_iss_index", REC_W'(bus.iss_index), '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    cdb(4'd6, 16'h0066);
    repeat (3) begin
      check("post_reset_no_issue", REC_W'(bus.iss_valid), '0);
      step();
    end
    check("post_reset_occ", REC_W'(occupancy), '0);

    check("queue_drained", REC_W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
